temp_poll_ctrl: RTL and testbench

Periodic temperature-sensor poll scheduler between the I2C master and the seven-segment display driver.
- Issues one read transaction to the on-board temperature sensor every poll period, or sooner on request.
- Supervises completion with a timeout and converts the raw 16-bit reading to a clamped 0–99 °C integer.
- Holds the result on `temp_data_o`, the display driver's `temp_data_i` source.
- Owns the I2C master's request side exclusively.

---
 rtl/temp_poll_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_temp_poll_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_poll_ctrl.sv
// temp_poll_ctrl
//   Periodic temperature-sensor poll scheduler. It issues one read to the
//   sensor through the I2C master every POLL_CYCLES clocks, or sooner on
//   force_i. It watches each transaction with a timeout and turns the raw
//   reading into a clamped 0..99 degC integer for the seven-segment driver.
//
//   Optional build macro: TEMP_POLL_AVG_EN
//     defined   : the display value is the truncated mean of the last four
//                 good samples. The first good sample after reset fills the
//                 whole window.
//     undefined : the display value is the latest clamped sample.
//
// Ports
//   clk_100MHz_i   in   system clock
//   rst_n_i        in   asynchronous active-low reset
//   force_i        in   one-cycle request for an immediate poll
//   i2c_busy_i     in   I2C master busy; holds off a new start
//   i2c_done_i     in   one-cycle transaction complete
//   i2c_ack_err_i  in   NACK flag, qualified by i2c_done_i
//   i2c_rdata_i    in   raw sensor word; bits [15:3] are 1/16 degC, two's complement
//   i2c_start_o    out  one-cycle transaction start (registered)
//   i2c_addr_o     out  constant SENSOR_ADDR
//   temp_data_o    out  display temperature, 0..99
//   valid_o        out  at least one good sample since reset
//   err_o          out  last transaction failed
//   err_cnt_o      out  failed-transaction count, saturating at 255
module temp_poll_ctrl #(
  parameter int unsigned POLL_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [6:0]  SENSOR_ADDR    = 7'h4B
) (
  input  logic        clk_100MHz_i,
  input  logic        rst_n_i,
  input  logic        force_i,
  input  logic        i2c_busy_i,
  input  logic        i2c_done_i,
  input  logic        i2c_ack_err_i,
  input  logic [15:0] i2c_rdata_i,
  output logic        i2c_start_o,
  output logic [6:0]  i2c_addr_o,
  output logic [7:0]  temp_data_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int PW = (POLL_CYCLES    > 1) ? $clog2(POLL_CYCLES)    : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_START,
    ST_BUSY,
    ST_LATCH,
    ST_FAIL
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_poll_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_pend;
  logic [6:0]      r_sample;
  logic            r_start;
  logic [7:0]      r_temp;
  logic            r_valid;
  logic            r_err;
  logic [7:0]      r_err_cnt;

  logic            w_poll_tc;
  logic            w_req;
  logic            w_issue;
  logic signed [8:0] w_t;
  logic [6:0]      w_clamp;
  logic            w_unused;

  // Only the integer-degree bits matter; the fraction and flag bits are dropped.
  assign w_unused = ^i2c_rdata_i[6:0];

  assign w_poll_tc = (r_poll_cnt == POLL_LAST);
  // Terminal count is folded in directly so consecutive starts land exactly
  // POLL_CYCLES apart rather than one cycle late through the pend flag.
  assign w_req     = r_pend | w_poll_tc;
  assign w_issue   = (r_state == ST_WAIT) && (w_next == ST_START);

  // Floor of degC is raw[15:7] as a signed 9-bit value; clamp to 0..99.
  assign w_t = $signed(i2c_rdata_i[15:7]);
  always_comb begin
    w_clamp = w_t[6:0];
    if (w_t[8])
      w_clamp = 7'd0;
    else if (w_t > 9'sd99)
      w_clamp = 7'd99;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_WAIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:  if (w_req && !i2c_busy_i) w_next = ST_START;
      ST_START: w_next = ST_BUSY;
      ST_BUSY: begin
        // A done pulse wins over an expiring timeout in the same cycle.
        if (i2c_done_i)            w_next = i2c_ack_err_i ? ST_FAIL : ST_LATCH;
        else if (r_to_cnt == '0)   w_next = ST_FAIL;
      end
      ST_LATCH: w_next = ST_WAIT;
      ST_FAIL:  w_next = ST_WAIT;
      default:  w_next = ST_WAIT;
    endcase
  end

  // ------------------------------------------------ poll counter / pend
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_poll_cnt <= '0;
      r_pend     <= 1'b1;
    end else begin
      if (w_issue || w_poll_tc) r_poll_cnt <= '0;
      else                      r_poll_cnt <= r_poll_cnt + 1'b1;

      // The START cycle consumes the request; a force arriving in that same
      // cycle belongs to the next transaction.
      if (r_state == ST_START)        r_pend <= force_i;
      else if (force_i || w_poll_tc)  r_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------- timeout counter
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_to_cnt <= '0;
    else if (r_state == ST_START)
      r_to_cnt <= TO_LAST;
    else if (r_state == ST_BUSY && r_to_cnt != '0)
      r_to_cnt <= r_to_cnt - 1'b1;
  end

  // ------------------------------------------------------ sample capture
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_sample <= '0;
    else if (r_state == ST_BUSY && i2c_done_i && !i2c_ack_err_i)
      r_sample <= w_clamp;
  end

  // ------------------------------------------------------- display value
`ifdef TEMP_POLL_AVG_EN
  // Entry 0 is the newest. The new mean uses the incoming sample plus the three
  // newest held entries, i.e. the window as it stands after the shift.
  logic [3:0][6:0] r_hist;
  logic [9:0]      w_sum;

  always_comb begin
    w_sum = {1'b0, r_sample, 2'b00};
    if (r_valid)
      w_sum = 10'(r_sample) + 10'(r_hist[0]) + 10'(r_hist[1]) + 10'(r_hist[2]);
  end

  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hist <= '0;
      r_temp <= '0;
    end else if (r_state == ST_LATCH) begin
      r_hist <= r_valid ? {r_hist[2:0], r_sample} : {4{r_sample}};
      r_temp <= 8'(w_sum >> 2);
    end
  end
`else
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_temp <= '0;
    else if (r_state == ST_LATCH)
      r_temp <= {1'b0, r_sample};
  end
`endif

  // ----------------------------------------------------- status outputs
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      // Registered copy of "in START", so the pulse lines up with that state.
      r_start <= w_issue;
      if (r_state == ST_LATCH) begin
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end
      if (r_state == ST_FAIL) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign i2c_start_o = r_start;
  assign i2c_addr_o  = SENSOR_ADDR;
  assign temp_data_o = r_temp;
  assign valid_o     = r_valid;
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Directed bench for temp_poll_ctrl (POLL_CYCLES=100, TIMEOUT_CYCLES=20).
// Stimulus pushes expected start cycles and expected output snapshots into
// queues. Separate negedge monitors pop and compare them when the DUT
// presents a start pulse or when the expected cycle is reached.
module tb_temp_poll_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_r = 1'b0, busy = 1'b0, done = 1'b0, ackerr = 1'b0;
  logic [15:0] rdata = '0;
  logic        start, valid, err;
  logic [6:0]  addr;
  logic [7:0]  temp, ecnt;

  always #5 clk = ~clk;

  temp_poll_ctrl #(.POLL_CYCLES(100), .TIMEOUT_CYCLES(20), .SENSOR_ADDR(7'h4B)) dut (
    .clk_100MHz_i(clk), .rst_n_i(rst_n), .force_i(force_r), .i2c_busy_i(busy),
    .i2c_done_i(done), .i2c_ack_err_i(ackerr), .i2c_rdata_i(rdata),
    .i2c_start_o(start), .i2c_addr_o(addr), .temp_data_o(temp),
    .valid_o(valid), .err_o(err), .err_cnt_o(ecnt));

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] temp;
    logic       valid;
    logic       err;
    logic [7:0] ecnt;
  } res_t;
  res_t res_q[$];
  int   start_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input string n, input logic [7:0] t,
                      input logic v, input logic e, input logic [7:0] ec);
    res_t r;
    r.cyc = c; r.name = n; r.temp = t; r.valid = v; r.err = e; r.ecnt = ec;
    res_q.push_back(r);
  endtask

  // Start-pulse monitor
  always @(negedge clk) begin : mon_start
    int e;
    if (start === 1'b1) begin
      if (start_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL start_unexpected: got start at cyc %0d expected none", cyc);
      end else begin
        e = start_q.pop_front();
        chk("start_cycle", cyc, e);
        chk("start_addr", addr, 7'h4B);
      end
    end
  end

  // Output-snapshot monitor
  always @(negedge clk) begin : mon_res
    res_t r;
    while (res_q.size() > 0 && res_q[0].cyc <= cyc) begin
      r = res_q.pop_front();
      if (r.cyc != cyc) begin
        checks++; failures++;
        $display("FAIL %s_missed: got cyc %0d expected cyc %0d", r.name, cyc, r.cyc);
      end else begin
        chk({r.name, "_temp"},  temp,  r.temp);
        chk({r.name, "_valid"}, valid, r.valid);
        chk({r.name, "_err"},   err,   r.err);
        chk({r.name, "_ecnt"},  ecnt,  r.ecnt);
      end
    end
  end

  // Averaging model for the optional build; identity otherwise.
  logic [6:0] win [4];
  bit         win_ok = 0;
  logic [7:0] last_t;
  function automatic logic [7:0] mdl(input logic [6:0] s);
`ifdef TEMP_POLL_AVG_EN
    if (!win_ok) win = '{s, s, s, s};
    else         win = '{s, win[0], win[1], win[2]};
    win_ok = 1;
    return 8'((10'(win[0]) + 10'(win[1]) + 10'(win[2]) + 10'(win[3])) >> 2);
`else
    return {1'b0, s};
`endif
  endfunction

  task automatic to_cyc(input int c);
    int guard = 0;
    while (cyc != c) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        checks++; failures++;
        $display("FAIL to_cyc: got cyc %0d expected %0d", cyc, c);
        break;
      end
    end
  endtask

  task automatic do_done(input int c, input logic [15:0] raw, input logic ae);
    to_cyc(c);
    done = 1'b1; rdata = raw; ackerr = ae;
    to_cyc(c + 1);
    done = 1'b0; ackerr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    push(0, "reset", 8'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    start_q.push_back(1);
    rst_n = 1'b1;

    // First poll: 16'h0C80 -> 25, two cycles after done
    push(3, "pre_latch", 8'd0, 1'b0, 1'b0, 8'd0);
    do_done(2, 16'h0C80, 1'b0);
    last_t = mdl(7'd25); push(4, "t25", last_t, 1'b1, 1'b0, 8'd0);

    // Periodic polls, conversion corners
    start_q.push_back(101);
    do_done(105, 16'hFF80, 1'b0);
    last_t = mdl(7'd0);  push(107, "neg", last_t, 1'b1, 1'b0, 8'd0);
    start_q.push_back(201);
    do_done(203, 16'h3880, 1'b0);
    last_t = mdl(7'd99); push(205, "hot", last_t, 1'b1, 1'b0, 8'd0);
    start_q.push_back(301);
    do_done(303, 16'h0C7F, 1'b0);
    last_t = mdl(7'd24); push(305, "t24", last_t, 1'b1, 1'b0, 8'd0);
    start_q.push_back(401);
    do_done(403, 16'h31FF, 1'b0);
    last_t = mdl(7'd99); push(405, "t99", last_t, 1'b1, 1'b0, 8'd0);

    // Timeout: no done in the 20 cycles after start at 501
    start_q.push_back(501);
    push(522, "to_pre", last_t, 1'b1, 1'b0, 8'd0);
    push(523, "timeout", last_t, 1'b1, 1'b1, 8'd1);
    // NACK
    start_q.push_back(601);
    do_done(603, 16'h0000, 1'b1);
    push(605, "nack", last_t, 1'b1, 1'b1, 8'd2);
    // Recovery
    start_q.push_back(701);
    do_done(703, 16'h0C80, 1'b0);
    last_t = mdl(7'd25); push(705, "recover", last_t, 1'b1, 1'b0, 8'd2);

    // Force during BUSY -> one extra start right after LATCH
    start_q.push_back(801);
    start_q.push_back(807);
    to_cyc(802); force_r = 1'b1;
    to_cyc(803); force_r = 1'b0;
    do_done(804, 16'h0C7F, 1'b0);
    last_t = mdl(7'd24); push(806, "force_busy", last_t, 1'b1, 1'b0, 8'd2);
    do_done(809, 16'h0C80, 1'b0);
    last_t = mdl(7'd25); push(811, "force_poll", last_t, 1'b1, 1'b0, 8'd2);

    // Force coinciding with terminal count -> single start
    start_q.push_back(907);
    to_cyc(906); force_r = 1'b1;
    to_cyc(907); force_r = 1'b0;
    do_done(909, 16'h3880, 1'b0);
    last_t = mdl(7'd99); push(911, "force_tc", last_t, 1'b1, 1'b0, 8'd2);

    // Busy held 30 cycles over the due poll -> start once busy falls
    start_q.push_back(1031);
    to_cyc(1000); busy = 1'b1;
    to_cyc(1030); busy = 1'b0;
    do_done(1033, 16'h0C80, 1'b0);
    last_t = mdl(7'd25); push(1035, "busy_delay", last_t, 1'b1, 1'b0, 8'd2);

    // Done outside BUSY is ignored
    do_done(1050, 16'hFF80, 1'b0);
    push(1052, "ign_done", last_t, 1'b1, 1'b0, 8'd2);
    do_done(1060, 16'h0000, 1'b1);
    push(1062, "ign_nack", last_t, 1'b1, 1'b0, 8'd2);

    // Asynchronous reset in the middle of a transaction (start pulse high)
    start_q.push_back(1131);
    to_cyc(1131);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_temp",  temp,  0);
    chk("arst_valid", valid, 0);
    chk("arst_err",   err,   0);
    chk("arst_ecnt",  ecnt,  0);
    win_ok = 0;
    push(0, "rst_hold", 8'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    start_q.push_back(1);
    rst_n = 1'b1;
    // Late done lands in the WAIT cycle after release and must be dropped
    do_done(0, 16'h3880, 1'b0);
    push(3, "late_done", 8'd0, 1'b0, 1'b0, 8'd0);

    // Samples 20, 24, 28, 32
`ifdef TEMP_POLL_AVG_EN
    push(4,   "s20", 8'd20, 1'b1, 1'b0, 8'd0);
    push(104, "s24", 8'd21, 1'b1, 1'b0, 8'd0);
    push(204, "s28", 8'd23, 1'b1, 1'b0, 8'd0);
    push(304, "s32", 8'd26, 1'b1, 1'b0, 8'd0);
`else
    push(4,   "s20", 8'd20, 1'b1, 1'b0, 8'd0);
    push(104, "s24", 8'd24, 1'b1, 1'b0, 8'd0);
    push(204, "s28", 8'd28, 1'b1, 1'b0, 8'd0);
    push(304, "s32", 8'd32, 1'b1, 1'b0, 8'd0);
`endif
    do_done(2, 16'h0A00, 1'b0);
    start_q.push_back(101);
    do_done(102, 16'h0C00, 1'b0);
    start_q.push_back(201);
    do_done(202, 16'h0E00, 1'b0);
    start_q.push_back(301);
    do_done(302, 16'h1000, 1'b0);

    to_cyc(320);
    chk("start_q_empty", start_q.size(), 0);
    chk("res_q_empty",   res_q.size(),   0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
